// File: rtl/select_decode_logic_if.sv
// Bus bundle between the control unit / IR source and the register-select
// decoder. The master drives the select requests and the instruction word;
// the slave (the decoder) returns the register enables, the latched IR fields
// and the selection error status.
interface select_decode_logic_if;
   logic        ir_load;
   logic [31:0] ir_in;
   logic        gra;
   logic        grb;
   logic        grc;
   logic        r_in;
   logic        r_out;
   logic        ba_out;
   logic [15:0] reg_in;
   logic [15:0] reg_out;
   logic        ba_zero;
   logic [4:0]  opcode;
   logic [31:0] c_sign_extended;
   logic        sel_error;
   logic [7:0]  error_count;

   modport master (
      output ir_load, ir_in, gra, grb, grc, r_in, r_out, ba_out,
      input  reg_in, reg_out, ba_zero, opcode, c_sign_extended,
             sel_error, error_count
   );

   modport slave (
      input  ir_load, ir_in, gra, grb, grc, r_in, r_out, ba_out,
      output reg_in, reg_out, ba_zero, opcode, c_sign_extended,
             sel_error, error_count
   );
endinterface

// File: rtl/select_decode_logic.sv
// Register-select decoder: latches the instruction register, turns the
// control unit's Ra/Rb/Rc field requests into registered one-hot R0-R15
// write/read enables, exposes the sign-extended C constant, and keeps a
// sticky flag plus a saturating count of multi-field selections.
module select_decode_logic (
   input logic                  clock,
   input logic                  clear,
   select_decode_logic_if.slave bus
);

   // IR field register (stage 0) and registered enables (stage 1)
   logic [31:0] ir_p0;
   logic [15:0] reg_in_p1;
   logic [15:0] reg_out_p1;
   logic        ba_zero_p1;
   logic        sel_error_q;
   logic [7:0]  err_cnt_q;

   // Field decode from the IR contents held before the current edge
   logic        fld_vld;
   logic [3:0]  fld;
   logic [1:0]  nsel;
   logic        multi_sel;
   logic [15:0] fld_onehot;

   function automatic logic [15:0] onehot16(input logic [3:0] idx);
      logic [15:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : (v + 8'd1);
   endfunction

   function automatic logic signed [31:0] sext19(input logic [18:0] c);
      return {{13{c[18]}}, c};
   endfunction

   // Priority field select (gra > grb > grc) and multi-select detection
   always_comb begin
      fld_vld = 1'b0;
      fld     = 4'd0;
      if (bus.gra) begin
         fld_vld = 1'b1;
         fld     = ir_p0[26:23];
      end else if (bus.grb) begin
         fld_vld = 1'b1;
         fld     = ir_p0[22:19];
      end else if (bus.grc) begin
         fld_vld = 1'b1;
         fld     = ir_p0[18:15];
      end
      nsel       = {1'b0, bus.gra} + {1'b0, bus.grb} + {1'b0, bus.grc};
      multi_sel  = (nsel >= 2'd2);
      fld_onehot = onehot16(fld);
   end

   // ---- stage 0: instruction register capture ----
   // IR holds until a load; a request on the load edge still sees the old IR
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         ir_p0 <= '0;
      end else if (bus.ir_load) begin
         ir_p0 <= bus.ir_in;
      end
   end

   // ---- stage 1: registered enables, one-cycle pulses ----
   // Enables are rebuilt every edge, so an unrepeated request lasts one cycle
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         reg_in_p1  <= '0;
         reg_out_p1 <= '0;
         ba_zero_p1 <= 1'b0;
      end else begin
         reg_in_p1  <= (bus.r_in && fld_vld) ? fld_onehot : 16'd0;
         reg_out_p1 <= ((bus.r_out || bus.ba_out) && fld_vld) ? fld_onehot : 16'd0;
         ba_zero_p1 <= bus.ba_out && fld_vld && (fld == 4'd0);
      end
   end

   // Sticky error flag and saturating error counter for multi-field selects
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         sel_error_q <= 1'b0;
         err_cnt_q   <= '0;
      end else if (multi_sel) begin
         sel_error_q <= 1'b1;
         err_cnt_q   <= sat_inc8(err_cnt_q);
      end
   end

   assign bus.reg_in          = reg_in_p1;
   assign bus.reg_out         = reg_out_p1;
   assign bus.ba_zero         = ba_zero_p1;
   assign bus.opcode          = ir_p0[31:27];
   assign bus.c_sign_extended = sext19(ir_p0[18:0]);
   assign bus.sel_error       = sel_error_q;
   assign bus.error_count     = err_cnt_q;

endmodule
